// File: rtl/miriscv_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : miriscv_irq_ctrl
//  Purpose  : Machine-mode interrupt controller. Masks 32 level-sensitive
//             request lines with mie, selects one pending line (round-robin
//             or fixed priority), issues a one-cycle trap pulse with the
//             matching mcause, and returns a one-hot completion pulse to the
//             serviced line when mret retires.
//  Ports    : clk, reset       - clock, synchronous active-high reset
//             irq_req_i[31:0]  - level-sensitive requests
//             mie_i[31:0]      - interrupt-enable mask
//             core_ready_i     - core can accept a trap this cycle
//             mret_i           - mret retiring (one-cycle pulse)
//             irq_o            - one-cycle trap pulse
//             mcause_o[31:0]   - cause of the current trap
//             irq_ret_o[31:0]  - one-hot completion pulse
//             busy_o           - trap taken and not yet completed
//  Revision : 1.0 - initial release
// ============================================================================
module miriscv_irq_ctrl #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] irq_req_i,
  input  logic [31:0] mie_i,
  input  logic        core_ready_i,
  input  logic        mret_i,
  output logic        irq_o,
  output logic [31:0] mcause_o,
  output logic [31:0] irq_ret_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRAP    = 2'd1,
    SERVICE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pend;
  logic [4:0]  cur_id;
  logic [4:0]  last_id;
  logic [4:0]  sel_id;
  logic        sel_valid;
  logic        take;

  assign pend = irq_req_i & mie_i;

  // Circular search starting at base. Fixed priority is the special case of
  // a search that always starts at line 0; round-robin starts one past the
  // last serviced line, the 5-bit add providing the 31 -> 0 wrap.
  always_comb begin
    logic [4:0] base;
    logic [4:0] idx;
    sel_id    = 5'd0;
    sel_valid = 1'b0;
    idx       = 5'd0;
    base      = RR_EN ? (last_id + 5'd1) : 5'd0;
    for (int i = 0; i < 32; i++) begin
      idx = base + 5'(i);
      if (!sel_valid && pend[idx]) begin
        sel_valid = 1'b1;
        sel_id    = idx;
      end
    end
  end

  // core_ready_i only matters in IDLE; once latched, the trap runs to
  // completion even if the request drops or gets masked.
  assign take = (state == IDLE) && sel_valid && core_ready_i;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take) state_next = TRAP;
      TRAP:    state_next = SERVICE;
      SERVICE: if (mret_i) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cur_id   <= 5'd0;
      last_id  <= 5'd31;
      mcause_o <= 32'd0;
    end else begin
      state <= state_next;
      if (take) begin
        cur_id   <= sel_id;
        mcause_o <= {1'b1, 26'd0, sel_id};
      end
      if (RR_EN && (state == DONE)) begin
        last_id <= cur_id;
      end
    end
  end

  // Outputs decode directly from the state register, so a reset in any
  // state clears them on the very next edge and an aborted trap never
  // produces a completion pulse.
  assign irq_o     = (state == TRAP);
  assign busy_o    = (state != IDLE);
  assign irq_ret_o = (state == DONE) ? (32'd1 << cur_id) : 32'd0;

endmodule
`default_nettype wire
